branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Bimodal branch predictor paired with branch_comp: predicts branch direction at fetch and learns from the resolved branch_taken outcome.
- Lookup is indexed by fetch PC. Updates arrive from the execute stage, where branch_comp resolves funct3 comparisons.
- Keeps saturating resolved-branch and mispredict statistics counters for performance debug.

Parameters:
INDEX_BITS, 6, table index width; table depth = 2**INDEX_BITS entries
XLEN, 32, PC and target width
CNT_W, 32, width of statistics counters

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
fetch_valid  input  1  lookup request this cycle
fetch_pc  input  XLEN  PC of fetched instruction
flush  input  1  squash in-flight lookup (pipeline redirect)
pred_valid  output  1  prediction valid, one cycle after fetch_valid
pred_taken  output  1  predicted direction
pred_target  output  XLEN  predicted target (BTB feature only)
upd_valid  input  1  resolved conditional branch this cycle
upd_pc  input  XLEN  PC of resolved branch
upd_taken  input  1  branch_taken from branch_comp
upd_pred_taken  input  1  prediction originally made for this branch
upd_target  input  XLEN  resolved taken target
mispredict  output  1  registered: previous-cycle update mispredicted
branch_count  output  CNT_W  resolved branches seen
mispredict_count  output  CNT_W  mispredictions seen

Behaviour:
- Reset (async on rst_n low, any cycle including mid-lookup):
  - All 2-bit counters = 2'b01 (weakly not-taken).
  - pred_valid, pred_taken, mispredict = 0; pred_target = 0.
  - branch_count, mispredict_count = 0.
  - BTB valid bits = 0 (BTB feature only).
- Index: idx = pc[INDEX_BITS+1:2]. PC bits [1:0] are ignored. No tag; aliasing PCs share an entry.
- Lookup, 1-cycle latency:
  - On an edge with fetch_valid=1 and flush=0: pred_valid<=1, pred_taken<=counter[idx][1].
  - Otherwise pred_valid<=0.
  - pred_taken and pred_target hold their last value when pred_valid=0.
- Flush: flush=1 forces pred_valid<=0 regardless of fetch_valid. Table and counters are unaffected.
- Update, on an edge with upd_valid=1:
  - upd_taken=1: counter increments, saturating at 2'b11.
  - upd_taken=0: counter decrements, saturating at 2'b00.
  - upd_valid=0: no table change.
- Simultaneous lookup and update to the same index: lookup returns the pre-update counter (read-before-write). The update is visible from the next lookup.
- Statistics:
  - branch_count increments on every upd_valid.
  - mispredict_count increments when upd_valid && (upd_taken != upd_pred_taken).
  - Both counters saturate at all-ones and never wrap.
- mispredict <= upd_valid && (upd_taken != upd_pred_taken), asserted for exactly one cycle per event.
- fetch_valid=1 and upd_valid=1 in the same cycle is legal and both are serviced.

Optional Feature:
BRANCH_PRED_BTB_EN
- Defined:
  - Adds a per-entry target register (XLEN) and valid bit.
  - On update with upd_taken=1: target[idx]<=upd_target, valid[idx]<=1. Not-taken updates leave the target untouched.
  - Lookup: pred_taken<=counter[idx][1] && valid[idx]; pred_target<=target[idx].
- Undefined:
  - No target storage.
  - pred_target is constant 0.
  - pred_taken comes from the counter alone.
  - upd_target is ignored.

Test Plan:
- Reset, then fetch_pc=32'h100 with fetch_valid=1 -> next cycle pred_valid=1, pred_taken=0; branch_count=0, mispredict_count=0.
- Two updates at upd_pc=32'h100 with upd_taken=1, upd_pred_taken=0 -> counter 01->10->11. Lookup of 32'h100 gives pred_taken=1. mispredict pulses twice; mispredict_count=2, branch_count=2.
- Saturation: four not-taken updates at 32'h100 -> counter 00 and held. Lookup gives pred_taken=0. A fifth not-taken update stays at 00.
- Same-cycle lookup and taken update at 32'h40 from counter 01 -> that lookup gives pred_taken=0; the following lookup gives pred_taken=1 (after a second taken update reaches 11, still 1).
- fetch_valid=1 with flush=1 -> pred_valid=0 next cycle. Drop rst_n mid-sequence -> all outputs and counters 0 immediately, without waiting for a clock edge.
- BTB_EN: taken update pc=32'h200, upd_target=32'h380, twice -> lookup of 32'h200 gives pred_taken=1, pred_target=32'h380. Aliasing pc=32'h300 (INDEX_BITS=6) returns the same entry.

Source files
------------

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal 2-bit branch predictor with statistics; optional BTB via BRANCH_PRED_BTB_EN
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int XLEN       = 32,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_valid,
    input  logic [XLEN-1:0]   fetch_pc,
    input  logic              flush,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_target,
    input  logic              upd_valid,
    input  logic [XLEN-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic              upd_pred_taken,
    input  logic [XLEN-1:0]   upd_target,
    output logic              mispredict,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  mispredict_count
);

    localparam int DEPTH = 1 << INDEX_BITS;

    // Word-aligned PCs: the two low bits carry no information, no tag is kept
    logic [INDEX_BITS-1:0] fetch_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    assign fetch_idx = fetch_pc[INDEX_BITS+1:2];
    assign upd_idx   = upd_pc[INDEX_BITS+1:2];

    logic                  mis_event;
    assign mis_event = upd_valid && (upd_taken != upd_pred_taken);

    logic [1:0]        cnt_q [DEPTH];
    logic [1:0]        cnt_d [DEPTH];
    logic              pred_valid_q, pred_valid_d;
    logic              pred_taken_q, pred_taken_d;
    logic [XLEN-1:0]   pred_target_q, pred_target_d;
    logic              mispredict_q, mispredict_d;
    logic [CNT_W-1:0]  branch_count_q, branch_count_d;
    logic [CNT_W-1:0]  mispredict_count_q, mispredict_count_d;

`ifdef BRANCH_PRED_BTB_EN
    logic [XLEN-1:0]   tgt_q [DEPTH];
    logic [XLEN-1:0]   tgt_d [DEPTH];
    logic [DEPTH-1:0]  tvld_q, tvld_d;

    // Taken updates record the resolved target and mark the entry usable
    always_comb begin
        tgt_d  = tgt_q;
        tvld_d = tvld_q;
        if (upd_valid && upd_taken) begin
            tgt_d[upd_idx]  = upd_target;
            tvld_d[upd_idx] = 1'b1;
        end
    end

    // Target store; only valid bits need a reset value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvld_q <= '0;
            for (int i = 0; i < DEPTH; i++) tgt_q[i] <= '0;
        end else begin
            tvld_q <= tvld_d;
            tgt_q  <= tgt_d;
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[XLEN-1:INDEX_BITS+2], fetch_pc[1:0],
                              upd_pc[XLEN-1:INDEX_BITS+2], upd_pc[1:0]};
`else
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[XLEN-1:INDEX_BITS+2], fetch_pc[1:0],
                              upd_pc[XLEN-1:INDEX_BITS+2], upd_pc[1:0], upd_target};
`endif

    // Saturating 2-bit counter training from resolved outcomes
    always_comb begin
        cnt_d = cnt_q;
        if (upd_valid) begin
            if (upd_taken) begin
                if (cnt_q[upd_idx] != 2'b11) cnt_d[upd_idx] = cnt_q[upd_idx] + 2'd1;
            end else begin
                if (cnt_q[upd_idx] != 2'b00) cnt_d[upd_idx] = cnt_q[upd_idx] - 2'd1;
            end
        end
    end

    // Lookup reads the pre-update table, so a same-cycle update is seen next time
    always_comb begin
        pred_valid_d  = fetch_valid && !flush;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        if (pred_valid_d) begin
`ifdef BRANCH_PRED_BTB_EN
            pred_taken_d  = cnt_q[fetch_idx][1] && tvld_q[fetch_idx];
            pred_target_d = tgt_q[fetch_idx];
`else
            pred_taken_d  = cnt_q[fetch_idx][1];
            pred_target_d = '0;
`endif
        end
    end

    // Statistics counters stick at all-ones instead of wrapping
    always_comb begin
        mispredict_d       = mis_event;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (upd_valid && (branch_count_q != {CNT_W{1'b1}}))
            branch_count_d = branch_count_q + CNT_W'(1);
        if (mis_event && (mispredict_count_q != {CNT_W{1'b1}}))
            mispredict_count_d = mispredict_count_q + CNT_W'(1);
    end

    // State registers; reset puts every entry at weakly not-taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) cnt_q[i] <= 2'b01;
            pred_valid_q       <= 1'b0;
            pred_taken_q       <= 1'b0;
            pred_target_q      <= '0;
            mispredict_q       <= 1'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            cnt_q              <= cnt_d;
            pred_valid_q       <= pred_valid_d;
            pred_taken_q       <= pred_taken_d;
            pred_target_q      <= pred_target_d;
            mispredict_q       <= mispredict_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign pred_valid       = pred_valid_q;
    assign pred_taken       = pred_taken_q;
    assign pred_target      = pred_target_q;
    assign mispredict       = mispredict_q;
    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        flush;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_pred_taken;
    logic [31:0] upd_target;
    logic        mispredict;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int vectors = 0;
    int miscompares = 0;

    branch_predictor #(.INDEX_BITS(6), .XLEN(32), .CNT_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fetch_valid      (fetch_valid),
        .fetch_pc         (fetch_pc),
        .flush            (flush),
        .pred_valid       (pred_valid),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_pred_taken   (upd_pred_taken),
        .upd_target       (upd_target),
        .mispredict       (mispredict),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        fetch_valid = 0; flush = 0; upd_valid = 0;
    endtask

    task automatic set_fetch(input logic [31:0] pc);
        fetch_valid = 1; fetch_pc = pc;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic tk, input logic ptk, input logic [31:0] tgt);
        upd_valid = 1; upd_pc = pc; upd_taken = tk; upd_pred_taken = ptk; upd_target = tgt;
    endtask

    initial begin
        rst_n = 0; fetch_valid = 0; fetch_pc = 0; flush = 0;
        upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_pred_taken = 0; upd_target = 0;
        @(negedge clk); @(negedge clk);
        check("rst_pred_valid", 32'(pred_valid), 0);
        check("rst_pred_taken", 32'(pred_taken), 0);
        check("rst_pred_target", pred_target, 0);
        check("rst_mispredict", 32'(mispredict), 0);
        check("rst_branch_cnt", branch_count, 0);
        check("rst_mis_cnt", mispredict_count, 0);
        rst_n = 1;

        // First lookup after reset: weakly not-taken
        set_fetch(32'h100); tick(); idle();
        check("lk0_valid", 32'(pred_valid), 1);
        check("lk0_taken", 32'(pred_taken), 0);

        // Two taken updates 01->10->11, both mispredicted
        set_upd(32'h100, 1, 0, 0); tick();
        check("up1_mis", 32'(mispredict), 1);
        check("up1_bcnt", branch_count, 1);
        set_upd(32'h100, 1, 0, 0); tick(); idle();
        check("up2_mis", 32'(mispredict), 1);
        check("up2_mcnt", mispredict_count, 2);
        set_fetch(32'h100); tick(); idle();
        check("lk1_taken", 32'(pred_taken), 1);
        check("lk1_mis_clear", 32'(mispredict), 0);
        check("lk1_bcnt", branch_count, 2);

        // Five not-taken updates, correctly predicted: saturate at 00
        for (int i = 0; i < 5; i++) begin
            set_upd(32'h100, 0, 0, 0); tick();
            check("nt_nomis", 32'(mispredict), 0);
        end
        idle();
        set_fetch(32'h100); tick(); idle();
        check("sat_taken", 32'(pred_taken), 0);
        // One taken from 00 reaches only 01, still not-taken
        set_upd(32'h100, 1, 0, 0); tick(); idle();
        set_fetch(32'h100); tick(); idle();
        check("sat_up_taken", 32'(pred_taken), 0);
        check("sat_bcnt", branch_count, 8);
        check("sat_mcnt", mispredict_count, 3);

        // Same-cycle lookup and update at 0x40: read-before-write
        set_fetch(32'h40); set_upd(32'h40, 1, 0, 0); tick();
        check("rbw_taken", 32'(pred_taken), 0);
        check("rbw_valid", 32'(pred_valid), 1);
        set_fetch(32'h40); set_upd(32'h40, 1, 0, 0); tick(); idle();
        check("rbw_next_taken", 32'(pred_taken), 1);
        set_fetch(32'h40); tick(); idle();
        check("rbw_sat_taken", 32'(pred_taken), 1);

        // Predicted taken, resolved not-taken counts as a mispredict
        set_upd(32'h80, 0, 1, 0); tick(); idle();
        check("mis_nt_pulse", 32'(mispredict), 1);
        check("mis_nt_mcnt", mispredict_count, 6);
        check("mis_nt_bcnt", branch_count, 11);
        tick();
        check("mis_one_cycle", 32'(mispredict), 0);
        check("hold_valid", 32'(pred_valid), 0);
        check("hold_taken", 32'(pred_taken), 1);

        // Flush squashes the lookup
        set_fetch(32'h40); flush = 1; tick(); idle();
        check("flush_valid", 32'(pred_valid), 0);

`ifdef BRANCH_PRED_BTB_EN
        set_upd(32'h200, 1, 0, 32'h380); tick();
        set_upd(32'h200, 1, 0, 32'h380); tick(); idle();
        set_fetch(32'h200); tick(); idle();
        check("btb_taken", 32'(pred_taken), 1);
        check("btb_target", pred_target, 32'h380);
        set_fetch(32'h300); tick(); idle();
        check("btb_alias_taken", 32'(pred_taken), 1);
        check("btb_alias_target", pred_target, 32'h380);
`else
        set_upd(32'h200, 1, 0, 32'h380); tick();
        set_upd(32'h200, 1, 0, 32'h380); tick(); idle();
        set_fetch(32'h300); tick(); idle();
        check("alias_taken", 32'(pred_taken), 1);
        check("nobtb_target", pred_target, 0);
`endif

        // Asynchronous reset mid-lookup, observed before any clock edge
        set_fetch(32'h40);
        #2 rst_n = 0;
        #1;
        check("arst_valid", 32'(pred_valid), 0);
        check("arst_taken", 32'(pred_taken), 0);
        check("arst_bcnt", branch_count, 0);
        check("arst_mcnt", mispredict_count, 0);
        check("arst_target", pred_target, 0);
        @(negedge clk); rst_n = 1;
        set_fetch(32'h40); tick(); idle();
        check("arst_table", 32'(pred_taken), 0);
        check("arst_lk_valid", 32'(pred_valid), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
